uart_tx_feeder: RTL and testbench
=================================

// Module: uart_tx_feeder
// PURPOSE
//  Byte buffer and pacing stage directly upstream of uart_tx.
//  Accepts solver/result bytes via a valid/ready handshake and stores them in a FIFO.
//  Presents one byte at a time to uart_tx as a single-cycle axiiv pulse, then waits
//  for uart_tx's done pulse before issuing the next byte.
// PARAMETERS
//  DEPTH      16     FIFO entries; power of 2, >=2
//  TIMEOUT    2000   cycles to wait for tx_done (only with UART_FEEDER_TIMEOUT_EN)
// PORTS
//  clk         in   1             system clock; all logic on rising edge
//  rst_n       in   1             async active-low reset
//  in_valid    in   1             producer byte valid
//  in_data     in   8             producer byte
//  in_ready    out  1             FIFO not full; byte accepted when in_valid&&in_ready
//  tx_axiiv    out  1             to uart_tx.axiiv; one-cycle start pulse
//  tx_axiid    out  8             to uart_tx.axiid; held stable from pulse until tx_done
//  tx_done     in   1             from uart_tx.done; one-cycle pulse at end of stop bit
//  level       out  $clog2(DEPTH)+1  bytes held in FIFO, excluding the byte in flight
//  busy        out  1             high while FSM is not IDLE or level!=0
//  err         out  1             sticky; set on timeout; cleared only by reset
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - FIFO emptied: level=0, in_ready=1.
//   - tx_axiiv=0, tx_axiid=8'h00, busy=0, err=0, FSM=IDLE.
//  FIFO
//   - Write when in_valid&&in_ready. Pop only on IDLE->SEND.
//   - Simultaneous push and pop: level unchanged.
//   - When full, in_ready=0 and in_data is ignored; no overwrite.
//   - Pointers wrap modulo DEPTH.
//  FSM (typedef tx_feed_state_t)
//   - IDLE: if level!=0, pop the head into tx_axiid register and go to SEND.
//   - SEND: tx_axiiv=1 for exactly this cycle; go to WAIT.
//   - WAIT: tx_axiiv=0, tx_axiid held. On tx_done go to IDLE.
//  Timing
//   - Latency from push into an empty idle FIFO to the tx_axiiv pulse is 2 cycles:
//     cycle n push, cycle n+1 pop into SEND, pulse visible n+1..n+2 edge.
//   - Back-to-back bytes: tx_done in cycle k gives the next tx_axiiv in cycle k+2.
//  Boundary conditions
//   - tx_done seen in IDLE or SEND is ignored.
//   - tx_done coinciding with a push is handled independently; no loss.
//   - Reset mid-WAIT drops the in-flight byte and all queued bytes.
// CONFIGURATION
//  UART_FEEDER_TIMEOUT_EN defined
//   - WAIT counts cycles. If TIMEOUT cycles pass with no tx_done: set err=1, return
//     to IDLE and drop the byte. The counter clears on entering WAIT.
//  UART_FEEDER_TIMEOUT_EN undefined
//   - WAIT waits indefinitely; err is tied to 0; no counter is synthesized.
// STRUCTURE
//  uart_pkg: tx_feed_state_t enum {IDLE,SEND,WAIT}; typedef logic [7:0] byte_t.
//  Sub-module sync_fifo #(WIDTH=8, DEPTH): push/pop/full/empty/level, async low reset.
//  Top level: the FSM, the tx_axiid register and the optional timeout counter.
// TESTING
//  1. Reset: rst_n low mid-run -> all outputs at reset values immediately; level=0.
//  2. Single byte: push 8'hAA into an idle block -> tx_axiiv 1-cycle pulse 2 cycles
//     later with tx_axiid=8'hAA; no second pulse before tx_done.
//  3. Burst: push 8'hAA, 8'hCC, 8'h55 back-to-back; model tx_done 100 cycles after
//     each pulse -> three pulses in order, each 2 cycles after the prior done.
//  4. Full: push DEPTH+2 bytes while tx_done is withheld -> in_ready=0 once level=DEPTH;
//     extra bytes dropped; level never exceeds DEPTH; order preserved on drain.
//  5. Spurious/simultaneous: tx_done in IDLE -> no effect; push coinciding with pop
//     -> level unchanged.
//  6. With UART_FEEDER_TIMEOUT_EN and TIMEOUT=50: no tx_done -> err=1 at cycle 50 of
//     WAIT and the next byte is sent; without the macro, still in WAIT at cycle 500.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit feeder.
// Combinational definitions only; no latency and no flow control.
// Imported by the feeder top level.
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } tx_feed_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy count and a show-ahead read port.
// Latency: a write is visible on pop_data in the cycle after the push.
// Backpressure: a push while full and a pop while empty are both ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             wr_en;
  logic             rd_en;

  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign wr_en    = push && !full;
  assign rd_en    = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers bytes and hands them to uart_tx one at a time (optional WAIT timeout: UART_FEEDER_TIMEOUT_EN).
// Latency: push into an empty idle block to tx_axiiv pulse is 2 cycles; tx_done to next pulse is 2 cycles.
// Backpressure: in_ready drops when the FIFO is full; the next byte waits for tx_done.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 2000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     tx_axiiv,
  output logic [7:0]               tx_axiid,
  input  logic                     tx_done,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     err
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_cfg_check
    $error("uart_tx_feeder: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  tx_feed_state_t state;
  tx_feed_state_t state_nxt;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  byte_t          head;
  logic           timeout_hit;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state != IDLE) || (level != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = SEND;
      SEND:    state_nxt = WAIT;
      WAIT:    if (tx_done || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_axiiv = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE:    pop = !fifo_empty;
      SEND:    tx_axiiv = 1'b1;
      default: ;
    endcase
  end

  // The byte leaves the FIFO on the pop, so level never counts the one in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   tx_axiid <= 8'h00;
    else if (pop) tx_axiid <= head;
  end

`ifdef UART_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              to_cnt <= '0;
    else if (state != WAIT)  to_cnt <= '0;
    else                     to_cnt <= to_cnt + 1'b1;
  end

  // A done arriving in the last allowed cycle still wins over the timeout.
  assign timeout_hit = (state == WAIT) && !tx_done && (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           err <= 1'b0;
    else if (timeout_hit) err <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: reset, single byte, burst, full FIFO, spurious done, timeout.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
`ifdef UART_FEEDER_TIMEOUT_EN
  localparam int GAP = 40;
`else
  localparam int GAP = 100;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       tx_axiiv;
  logic [7:0] tx_axiid;
  logic       tx_done;
  logic [4:0] level;
  logic       busy;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] got [$];

  uart_tx_feeder #(
    .DEPTH   (DEPTH),
    .TIMEOUT (50)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .tx_axiiv (tx_axiiv),
    .tx_axiid (tx_axiid),
    .tx_done  (tx_done),
    .level    (level),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idles n cycles expecting no pulse, then one tx_done cycle; leaves the bench 2 cycles past done.
  task automatic done_after(input int n);
    int p;
    p = 0;
    for (int c = 0; c < n; c++) begin
      tick();
      if (tx_axiiv) p++;
    end
    chk("no_early_pulse", 32'(p), 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("no_pulse_k_plus_1", 32'(tx_axiiv), 32'd0);
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_level"},    32'(level),    32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_axiiv"},    32'(tx_axiiv), 32'd0);
    chk({tag, "_axiid"},    32'(tx_axiid), 32'h00);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_err"},      32'(err),      32'd0);
  endtask

  initial begin
    int ovf;
    int p;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tx_done  = 1'b0;
    #12;
    chk_reset_outputs("por");
    tick();
    rst_n = 1'b1;
    tick();

    // Single byte
    in_valid = 1'b1;
    in_data  = 8'hAA;
    tick();
    in_valid = 1'b0;
    chk("single_level1", 32'(level),    32'd1);
    chk("single_nopulse", 32'(tx_axiiv), 32'd0);
    chk("single_busy",   32'(busy),     32'd1);
    tick();
    chk("single_pulse",  32'(tx_axiiv), 32'd1);
    chk("single_data",   32'(tx_axiid), 32'hAA);
    chk("single_level0", 32'(level),    32'd0);
    done_after(10);
    chk("single_idle",   32'(busy),     32'd0);

    // Burst of three; the second push coincides with the first pop
    in_valid = 1'b1;
    in_data  = 8'hAA;
    tick();
    chk("burst_lvl_a", 32'(level), 32'd1);
    in_data = 8'hCC;
    tick();
    chk("push_pop_level", 32'(level), 32'd1);
    chk("burst_p0",    32'(tx_axiiv), 32'd1);
    chk("burst_d0",    32'(tx_axiid), 32'hAA);
    in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    chk("burst_lvl_c", 32'(level),    32'd2);
    chk("burst_off",   32'(tx_axiiv), 32'd0);
    done_after(GAP - 2);
    chk("burst_p1",    32'(tx_axiiv), 32'd1);
    chk("burst_d1",    32'(tx_axiid), 32'hCC);
    chk("burst_lvl1",  32'(level),    32'd1);
    done_after(GAP - 1);
    chk("burst_p2",    32'(tx_axiiv), 32'd1);
    chk("burst_d2",    32'(tx_axiid), 32'h55);
    done_after(GAP - 1);
    chk("burst_end",   32'(tx_axiiv), 32'd0);
    chk("burst_idle",  32'(busy),     32'd0);

    // Spurious done in IDLE and in SEND, done coinciding with push
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("spur_idle_busy", 32'(busy), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    tx_done  = 1'b1;
    tick();
    in_valid = 1'b0;
    tx_done  = 1'b0;
    chk("spur_push_level", 32'(level),    32'd1);
    tick();
    chk("spur_pulse",      32'(tx_axiiv), 32'd1);
    chk("spur_data",       32'(tx_axiid), 32'h3C);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    chk("done_in_send_ignored", 32'(busy), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h11;
    tx_done  = 1'b1;
    tick();
    in_valid = 1'b0;
    tx_done  = 1'b0;
    chk("done_push_level", 32'(level),    32'd1);
    chk("done_push_nopls", 32'(tx_axiiv), 32'd0);
    tick();
    chk("done_push_pulse", 32'(tx_axiiv), 32'd1);
    chk("done_push_data",  32'(tx_axiid), 32'h11);
    done_after(3);
    chk("spur_idle_end",   32'(busy),     32'd0);

    // Fill past capacity with done withheld
    got.delete();
    ovf = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h80 + i);
      chk($sformatf("full_rdy%0d", i), 32'(in_ready), (i <= DEPTH) ? 32'd1 : 32'd0);
      tick();
      if (tx_axiiv) got.push_back(tx_axiid);
      if (level > 5'(DEPTH)) ovf++;
    end
    in_valid = 1'b0;
    chk("full_level",   32'(level),    32'(DEPTH));
    chk("full_ready",   32'(in_ready), 32'd0);
    chk("full_no_ovf",  32'(ovf),      32'd0);
    for (int j = 0; j < DEPTH + 1; j++) begin
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tick();
      if (tx_axiiv) got.push_back(tx_axiid);
      tick();
    end
    chk("drain_count", 32'(got.size()), 32'(DEPTH + 1));
    for (int j = 0; j < got.size(); j++)
      chk($sformatf("drain_d%0d", j), 32'(got[j]), 32'(8'(8'h80 + j)));
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_busy",  32'(busy),  32'd0);

`ifdef UART_FEEDER_TIMEOUT_EN
    in_valid = 1'b1;
    in_data  = 8'hA1;
    tick();
    in_data = 8'hA2;
    tick();
    in_valid = 1'b0;
    chk("to_pulse_a1", 32'(tx_axiid), 32'hA1);
    repeat (50) tick();
    chk("to_err_before", 32'(err),      32'd0);
    tick();
    chk("to_err_set",    32'(err),      32'd1);
    chk("to_idle",       32'(tx_axiiv), 32'd0);
    tick();
    chk("to_next_pulse", 32'(tx_axiiv), 32'd1);
    chk("to_next_data",  32'(tx_axiid), 32'hA2);
    done_after(5);
    chk("to_err_sticky", 32'(err),      32'd1);
`else
    in_valid = 1'b1;
    in_data  = 8'hA1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("nto_pulse", 32'(tx_axiiv), 32'd1);
    p = 0;
    repeat (500) begin
      tick();
      if (tx_axiiv) p++;
    end
    chk("nto_no_pulse", 32'(p),    32'd0);
    chk("nto_waiting",  32'(busy), 32'd1);
    chk("nto_err",      32'(err),  32'd0);
    done_after(0);
    chk("nto_idle",     32'(busy), 32'd0);
`endif

    // Reset mid-WAIT with bytes queued
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (2) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("midrst");
    #2;
    rst_n = 1'b1;
    p = 0;
    repeat (6) begin
      tick();
      if (tx_axiiv) p++;
    end
    chk("post_rst_no_pulse", 32'(p),     32'd0);
    chk("post_rst_level",    32'(level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
